// File: rtl/id_operand_issue_if.sv
// Handshake bundles around the ID/EX issue slot.
// id_in_if carries the decoder offer, id_out_if carries the issued slot.
interface id_in_if #(
   parameter int AW     = 16,
   parameter int DW     = 16,
   parameter int RAW    = 4,
   parameter int CTRL_W = 8
) ();
   logic              valid;
   logic              ready;
   logic [AW-1:0]     pc;
   logic [CTRL_W-1:0] ctrl;
   logic              re0;
   logic              re1;
   logic [RAW-1:0]    raddr0;
   logic [RAW-1:0]    raddr1;
   logic [DW-1:0]     imm;
   logic              we;
   logic [RAW-1:0]    waddr;
   logic              is_load;

   modport master (
      output valid, pc, ctrl, re0, re1, raddr0, raddr1,
      output imm, we, waddr, is_load,
      input  ready
   );
   modport slave (
      input  valid, pc, ctrl, re0, re1, raddr0, raddr1,
      input  imm, we, waddr, is_load,
      output ready
   );
endinterface

interface id_out_if #(
   parameter int AW     = 16,
   parameter int DW     = 16,
   parameter int RAW    = 4,
   parameter int CTRL_W = 8
) ();
   logic              valid;
   logic              ready;
   logic [AW-1:0]     pc;
   logic [CTRL_W-1:0] ctrl;
   logic [DW-1:0]     op0;
   logic [DW-1:0]     op1;
   logic              we;
   logic [RAW-1:0]    waddr;
   logic              is_load;

   modport master (
      output valid, pc, ctrl, op0, op1, we, waddr, is_load,
      input  ready
   );
   modport slave (
      input  valid, pc, ctrl, op0, op1, we, waddr, is_load,
      output ready
   );
endinterface

// File: rtl/id_operand_issue.sv
// Decode-to-execute issue slot with operand forwarding and load-use stall.
// Define ID_WB_FWD_EN to add a lowest-priority WB forwarding source.
module id_operand_issue #(
   parameter int DW     = 16,
   parameter int AW     = 16,
   parameter int RAW    = 4,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   id_in_if.slave           in_if,
   id_out_if.master         out_if,
   input  logic [DW-1:0]    rf_rdata0_i,
   input  logic [DW-1:0]    rf_rdata1_i,
   input  logic             ex_we_i,
   input  logic [RAW-1:0]   ex_waddr_i,
   input  logic [DW-1:0]    ex_wdata_i,
   input  logic             ex_is_load_i,
   input  logic             mem_we_i,
   input  logic [RAW-1:0]   mem_waddr_i,
   input  logic [DW-1:0]    mem_wdata_i,
`ifdef ID_WB_FWD_EN
   input  logic             wb_we_i,
   input  logic [RAW-1:0]   wb_waddr_i,
   input  logic [DW-1:0]    wb_wdata_i,
`endif
   input  logic             flush_i,
   output logic [CNT_W-1:0] stall_cnt_o
);

   typedef enum logic [1:0] {RUN, LU, HOLD} state_t;

   state_t            state_q;
   logic              valid_q;
   logic [AW-1:0]     pc_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [DW-1:0]     op0_q, op0_d;
   logic [DW-1:0]     op1_q, op1_d;
   logic              we_q;
   logic [RAW-1:0]    waddr_q;
   logic              is_load_q;
   logic [CNT_W-1:0]  cnt_q;

   logic ex_hit0, ex_hit1, mem_hit0, mem_hit1;
   logic lu, hold, xfer;

   assign ex_hit0  = ex_we_i  & (ex_waddr_i  == in_if.raddr0);
   assign ex_hit1  = ex_we_i  & (ex_waddr_i  == in_if.raddr1);
   assign mem_hit0 = mem_we_i & (mem_waddr_i == in_if.raddr0);
   assign mem_hit1 = mem_we_i & (mem_waddr_i == in_if.raddr1);

   // Only a load still in EX cannot be forwarded in time.
   assign lu = in_if.valid & ex_is_load_i & ex_we_i &
               ((in_if.re0 & ex_hit0) | (in_if.re1 & ex_hit1));

   assign hold = valid_q & ~out_if.ready;
   assign in_if.ready = ~flush_i & ~lu & (~valid_q | out_if.ready);
   assign xfer = in_if.valid & in_if.ready;

   always_comb begin
      op0_d = rf_rdata0_i;
      priority case (1'b1)
         !in_if.re0: op0_d = '0;
         ex_hit0:    op0_d = ex_wdata_i;
         mem_hit0:   op0_d = mem_wdata_i;
`ifdef ID_WB_FWD_EN
         (wb_we_i && wb_waddr_i == in_if.raddr0):
                     op0_d = wb_wdata_i;
`endif
         default:    op0_d = rf_rdata0_i;
      endcase
   end

   always_comb begin
      op1_d = rf_rdata1_i;
      priority case (1'b1)
         !in_if.re1: op1_d = in_if.imm;
         ex_hit1:    op1_d = ex_wdata_i;
         mem_hit1:   op1_d = mem_wdata_i;
`ifdef ID_WB_FWD_EN
         (wb_we_i && wb_waddr_i == in_if.raddr1):
                     op1_d = wb_wdata_i;
`endif
         default:    op1_d = rf_rdata1_i;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= RUN;
         valid_q   <= 1'b0;
         pc_q      <= '0;
         ctrl_q    <= '0;
         op0_q     <= '0;
         op1_q     <= '0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         is_load_q <= 1'b0;
         cnt_q     <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
         state_q <= RUN;
      end else begin
         if (!hold) begin
            valid_q <= xfer;
            if (lu && cnt_q != '1)
               cnt_q <= cnt_q + 1'b1;
         end
         if (xfer) begin
            pc_q      <= in_if.pc;
            ctrl_q    <= in_if.ctrl;
            op0_q     <= op0_d;
            op1_q     <= op1_d;
            we_q      <= in_if.we;
            waddr_q   <= in_if.waddr;
            is_load_q <= in_if.is_load;
         end
         unique case (state_q)
            RUN:     state_q <= hold ? HOLD : (lu ? LU : RUN);
            LU:      state_q <= hold ? HOLD : RUN;
            HOLD:    state_q <= hold ? HOLD : (lu ? LU : RUN);
            default: state_q <= RUN;
         endcase
      end
   end

   assign out_if.valid   = valid_q;
   assign out_if.pc      = pc_q;
   assign out_if.ctrl    = ctrl_q;
   assign out_if.op0     = op0_q;
   assign out_if.op1     = op1_q;
   assign out_if.we      = we_q;
   assign out_if.waddr   = waddr_q;
   assign out_if.is_load = is_load_q;
   assign stall_cnt_o    = cnt_q;

endmodule

// File: tb/tb_id_operand_issue.sv
// Random + directed bench for id_operand_issue.
// Scoreboard queue filled by the driver, drained by a monitor.
module tb_id_operand_issue;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   id_in_if  ii ();
   id_out_if oi ();

   logic [15:0]   rf0, rf1, ex_wdata, mem_wdata;
   logic          ex_we, ex_is_load, mem_we, flush;
   logic [3:0]    ex_waddr, mem_waddr;
   logic [CW-1:0] stall_cnt;
`ifdef ID_WB_FWD_EN
   logic          wb_we;
   logic [3:0]    wb_waddr;
   logic [15:0]   wb_wdata;
`endif

   id_operand_issue #(.CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_if        (ii),
      .out_if       (oi),
      .rf_rdata0_i  (rf0),
      .rf_rdata1_i  (rf1),
      .ex_we_i      (ex_we),
      .ex_waddr_i   (ex_waddr),
      .ex_wdata_i   (ex_wdata),
      .ex_is_load_i (ex_is_load),
      .mem_we_i     (mem_we),
      .mem_waddr_i  (mem_waddr),
      .mem_wdata_i  (mem_wdata),
`ifdef ID_WB_FWD_EN
      .wb_we_i      (wb_we),
      .wb_waddr_i   (wb_waddr),
      .wb_wdata_i   (wb_wdata),
`endif
      .flush_i      (flush),
      .stall_cnt_o  (stall_cnt)
   );

   int checks = 0;
   int fails  = 0;
   logic [61:0] q[$];
   logic          m_ov;
   logic [CW-1:0] m_cnt;

   task automatic chk(string n, logic [63:0] a, logic [63:0] e);
      checks++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   function automatic logic [15:0] mop(logic re, logic [3:0] a,
                                       logic [15:0] rf, logic [15:0] alt);
      if (!re) return alt;
      if (ex_we && ex_waddr == a) return ex_wdata;
      if (mem_we && mem_waddr == a) return mem_wdata;
`ifdef ID_WB_FWD_EN
      if (wb_we && wb_waddr == a) return wb_wdata;
`endif
      return rf;
   endfunction

   task automatic idle();
      ii.valid = 0; ii.pc = 0; ii.ctrl = 0; ii.re0 = 0; ii.re1 = 0;
      ii.raddr0 = 0; ii.raddr1 = 0; ii.imm = 0; ii.we = 0;
      ii.waddr = 0; ii.is_load = 0; oi.ready = 1;
      rf0 = 0; rf1 = 0; ex_we = 0; ex_waddr = 0; ex_wdata = 0;
      ex_is_load = 0; mem_we = 0; mem_waddr = 0; mem_wdata = 0;
      flush = 0;
`ifdef ID_WB_FWD_EN
      wb_we = 0; wb_waddr = 0; wb_wdata = 0;
`endif
   endtask

   task automatic offer(logic [15:0] pc, logic re0, logic [3:0] a0,
                        logic re1, logic [3:0] a1, logic [15:0] imm);
      ii.valid = 1; ii.pc = pc; ii.ctrl = pc[7:0] ^ 8'h5A;
      ii.re0 = re0; ii.raddr0 = a0; ii.re1 = re1; ii.raddr1 = a1;
      ii.imm = imm; ii.we = 1; ii.waddr = pc[3:0]; ii.is_load = pc[0];
   endtask

   task automatic rnd();
      ii.valid = ($urandom_range(0, 3) != 0);
      ii.pc = 16'($urandom); ii.ctrl = 8'($urandom);
      ii.re0 = 1'($urandom); ii.re1 = 1'($urandom);
      ii.raddr0 = 4'($urandom_range(0, 3));
      ii.raddr1 = 4'($urandom_range(0, 3));
      ii.imm = 16'($urandom); ii.we = 1'($urandom);
      ii.waddr = 4'($urandom); ii.is_load = 1'($urandom);
      oi.ready = ($urandom_range(0, 3) != 0);
      rf0 = 16'($urandom); rf1 = 16'($urandom);
      ex_we = 1'($urandom); ex_waddr = 4'($urandom_range(0, 3));
      ex_wdata = 16'($urandom);
      ex_is_load = ($urandom_range(0, 3) == 0);
      mem_we = 1'($urandom); mem_waddr = 4'($urandom_range(0, 3));
      mem_wdata = 16'($urandom);
      flush = ($urandom_range(0, 15) == 0);
`ifdef ID_WB_FWD_EN
      wb_we = 1'($urandom); wb_waddr = 4'($urandom_range(0, 3));
      wb_wdata = 16'($urandom);
`endif
   endtask

   // Inputs are set at a falling edge; step checks and advances one cycle.
   task automatic step();
      logic lu, rdy, hold;
      #1;
      lu = ii.valid & ex_is_load & ex_we &
           ((ii.re0 & ex_waddr == ii.raddr0) |
            (ii.re1 & ex_waddr == ii.raddr1));
      rdy = !flush & !lu & (!m_ov | oi.ready);
      hold = m_ov & !oi.ready;
      chk("in_ready", 64'(ii.ready), 64'(rdy));
      chk("out_valid", 64'(oi.valid), 64'(m_ov));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      if (ii.valid && rdy)
         q.push_back({ii.pc, ii.ctrl,
                      mop(ii.re0, ii.raddr0, rf0, 16'h0),
                      mop(ii.re1, ii.raddr1, rf1, ii.imm),
                      ii.we, ii.waddr, ii.is_load});
      if (flush) m_ov = 0;
      else if (!hold) begin
         m_ov = ii.valid & rdy;
         if (lu && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      end
      @(negedge clk);
   endtask

   // Monitor: pop once when a new slot appears, then require it stable.
   initial begin : monitor
      logic pend;
      logic [61:0] last, act;
      pend = 0;
      last = '0;
      forever begin
         @(negedge clk);
         #2;
         act = {oi.pc, oi.ctrl, oi.op0, oi.op1, oi.we, oi.waddr, oi.is_load};
         if (!rst) pend = 0;
         else if (oi.valid) begin
            if (!pend) begin
               if (q.size() == 0)
                  chk("pop_empty", 64'(act), 64'hFFFF_FFFF_FFFF_FFFF);
               else begin
                  last = q.pop_front();
                  chk("slot", 64'(act), 64'(last));
               end
               pend = 1;
            end else
               chk("slot_stable", 64'(act), 64'(last));
            if (oi.ready) pend = 0;
         end else
            pend = 0;
      end
   end

   initial begin
      idle();
      m_ov = 0;
      m_cnt = '0;
      #12;
      chk("rst_valid", 64'(oi.valid), 64'h0);
      chk("rst_cnt", 64'(stall_cnt), 64'h0);
      chk("rst_slot", 64'({oi.pc, oi.ctrl, oi.op0, oi.op1, oi.we,
                           oi.waddr, oi.is_load}), 64'h0);
      @(negedge clk);
      rst = 1;
      step();
      // ADDIU R1, 5 from register file
      offer(16'h0100, 1, 4'd1, 0, 4'd0, 16'h0005);
      rf0 = 16'h0010;
      step();
      idle(); step();
      // EX beats MEM on R2
      offer(16'h0102, 1, 4'd2, 0, 4'd0, 16'h0007);
      ex_we = 1; ex_waddr = 2; ex_wdata = 16'hAAAA;
      mem_we = 1; mem_waddr = 2; mem_wdata = 16'h5555;
      step();
      idle(); step();
      // load-use on R3, then forwarded from MEM
      offer(16'h0104, 1, 4'd3, 0, 4'd0, 16'h0001);
      ex_is_load = 1; ex_we = 1; ex_waddr = 3; ex_wdata = 16'hDEAD;
      step();
      ex_is_load = 0; ex_we = 0;
      mem_we = 1; mem_waddr = 3; mem_wdata = 16'h1234;
      step();
      idle(); step();
      // back-pressure for 3 cycles
      offer(16'h0106, 1, 4'd1, 1, 4'd2, 16'h0);
      rf0 = 16'h1111; rf1 = 16'h2222;
      step();
      offer(16'h0108, 1, 4'd1, 0, 4'd0, 16'h0009);
      oi.ready = 0;
      repeat (3) step();
      oi.ready = 1;
      step();
      idle(); step();
      // flush kills slot and offer
      offer(16'h010A, 0, 4'd0, 0, 4'd0, 16'h000A);
      step();
      offer(16'h010C, 0, 4'd0, 0, 4'd0, 16'h000C);
      oi.ready = 0; flush = 1;
      step();
      idle(); step();
      // async reset in the middle of HOLD
      offer(16'h010E, 1, 4'd1, 0, 4'd0, 16'h000E);
      step();
      oi.ready = 0; ii.valid = 0;
      step();
      ex_is_load = 1; ex_we = 1; ex_waddr = 1; ii.valid = 1;
      oi.ready = 1;
      step();
      oi.ready = 0; ii.valid = 0; ex_is_load = 0; ex_we = 0;
      offer(16'h0110, 0, 4'd0, 0, 4'd0, 16'h0010);
      step();
      #3 rst = 0;
      #1;
      chk("mid_rst_valid", 64'(oi.valid), 64'h0);
      chk("mid_rst_cnt", 64'(stall_cnt), 64'h0);
      q.delete();
      m_ov = 0;
      m_cnt = '0;
      @(negedge clk);
      rst = 1;
      idle(); step();
`ifdef ID_WB_FWD_EN
      offer(16'h0112, 0, 4'd0, 1, 4'd4, 16'h0);
      wb_we = 1; wb_waddr = 4; wb_wdata = 16'hBEEF; rf1 = 16'h0;
      step();
      idle(); step();
`endif
      // saturate the stall counter
      offer(16'h0114, 1, 4'd5, 0, 4'd0, 16'h0);
      ex_is_load = 1; ex_we = 1; ex_waddr = 5;
      repeat (20) step();
      idle(); step();
      repeat (600) begin
         rnd();
         step();
      end
      idle();
      repeat (4) step();
      chk("queue_empty", 64'(q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end
endmodule
